// File: rtl/id_ex_hazard_if.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_if
// Bundle between the ID stage, the ID/EX pipeline register and EX.
//   ID side      : IF_ID_Rs/Rt/Rd, ID_ReadData1/2, ID_SignExtImm, ID_* control,
//                  flush (branch/jump redirect squashes the ID instruction)
//   EX side      : ID_EX_* registered specifiers, operands and control
//   Upstream     : PCWrite, IF_ID_Write (0 = hold), stall, stall_count
// Modports: master = ID/EX surroundings (drives ID side, observes results),
//           slave  = the pipeline stage itself.
// ---------------------------------------------------------------------------
interface id_ex_hazard_if #(
  parameter int BIT_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [BIT_WIDTH-1:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
  logic [DATA_WIDTH-1:0] ID_ReadData1, ID_ReadData2, ID_SignExtImm;
  logic                  ID_RegWrite, ID_MemToReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst;
  logic [1:0]            ID_ALUOp;
  logic                  flush;

  logic [BIT_WIDTH-1:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic [DATA_WIDTH-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm;
  logic                  ID_EX_RegWrite, ID_EX_MemToReg, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc, ID_EX_RegDst;
  logic [1:0]            ID_EX_ALUOp;
  logic                  PCWrite, IF_ID_Write, stall;
  logic [CNT_WIDTH-1:0]  stall_count;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, ID_ReadData1, ID_ReadData2, ID_SignExtImm,
           ID_RegWrite, ID_MemToReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst,
           ID_ALUOp, flush,
    input  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm,
           ID_EX_RegWrite, ID_EX_MemToReg, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc,
           ID_EX_RegDst, ID_EX_ALUOp, PCWrite, IF_ID_Write, stall, stall_count
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, ID_ReadData1, ID_ReadData2, ID_SignExtImm,
           ID_RegWrite, ID_MemToReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst,
           ID_ALUOp, flush,
    output ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm,
           ID_EX_RegWrite, ID_EX_MemToReg, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc,
           ID_EX_RegDst, ID_EX_ALUOp, PCWrite, IF_ID_Write, stall, stall_count
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset (state becomes a NOP bubble)
//   bus  - id_ex_hazard_if.slave: ID inputs + flush in; ID_EX_* registers,
//          PCWrite/IF_ID_Write/stall and the saturating stall_count out
// A load in EX whose rt feeds the instruction in ID costs exactly one bubble:
// the bubble clears ID_EX_MemRead, so the hazard disappears the next cycle.
// ---------------------------------------------------------------------------
module id_ex_hazard_stage #(
  parameter int BIT_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  id_ex_hazard_if.slave    bus
);

  localparam logic [BIT_WIDTH-1:0]  SPEC_ZERO = {BIT_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

  logic load_use;

  // Load-use detect: a load in EX targeting a register read by ID. $zero never conflicts.
  always_comb begin
    load_use = 1'b0;
    if (bus.ID_EX_MemRead && (bus.ID_EX_Rt != SPEC_ZERO) &&
        ((bus.ID_EX_Rt == bus.IF_ID_Rs) || (bus.ID_EX_Rt == bus.IF_ID_Rt))) begin
      load_use = 1'b1;
    end else begin
      load_use = 1'b0;
    end
  end

  // A redirect must never be held, so flush overrides the hold request.
  assign bus.stall       = load_use;
  assign bus.PCWrite     = ~load_use | bus.flush;
  assign bus.IF_ID_Write = ~load_use | bus.flush;

  // Pipeline register: flush squashes everything, a stall bubbles only the control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ID_EX_Rs         <= SPEC_ZERO;
      bus.ID_EX_Rt         <= SPEC_ZERO;
      bus.ID_EX_Rd         <= SPEC_ZERO;
      bus.ID_EX_ReadData1  <= DATA_ZERO;
      bus.ID_EX_ReadData2  <= DATA_ZERO;
      bus.ID_EX_SignExtImm <= DATA_ZERO;
      bus.ID_EX_RegWrite   <= 1'b0;
      bus.ID_EX_MemToReg   <= 1'b0;
      bus.ID_EX_MemRead    <= 1'b0;
      bus.ID_EX_MemWrite   <= 1'b0;
      bus.ID_EX_ALUSrc     <= 1'b0;
      bus.ID_EX_RegDst     <= 1'b0;
      bus.ID_EX_ALUOp      <= 2'b00;
    end else if (bus.flush) begin
      bus.ID_EX_Rs         <= SPEC_ZERO;
      bus.ID_EX_Rt         <= SPEC_ZERO;
      bus.ID_EX_Rd         <= SPEC_ZERO;
      bus.ID_EX_ReadData1  <= DATA_ZERO;
      bus.ID_EX_ReadData2  <= DATA_ZERO;
      bus.ID_EX_SignExtImm <= DATA_ZERO;
      bus.ID_EX_RegWrite   <= 1'b0;
      bus.ID_EX_MemToReg   <= 1'b0;
      bus.ID_EX_MemRead    <= 1'b0;
      bus.ID_EX_MemWrite   <= 1'b0;
      bus.ID_EX_ALUSrc     <= 1'b0;
      bus.ID_EX_RegDst     <= 1'b0;
      bus.ID_EX_ALUOp      <= 2'b00;
    end else begin
      // Specifiers and data are captured even under a stall; only control is bubbled.
      bus.ID_EX_Rs         <= bus.IF_ID_Rs;
      bus.ID_EX_Rt         <= bus.IF_ID_Rt;
      bus.ID_EX_Rd         <= bus.IF_ID_Rd;
      bus.ID_EX_ReadData1  <= bus.ID_ReadData1;
      bus.ID_EX_ReadData2  <= bus.ID_ReadData2;
      bus.ID_EX_SignExtImm <= bus.ID_SignExtImm;
      if (load_use) begin
        bus.ID_EX_RegWrite <= 1'b0;
        bus.ID_EX_MemToReg <= 1'b0;
        bus.ID_EX_MemRead  <= 1'b0;
        bus.ID_EX_MemWrite <= 1'b0;
        bus.ID_EX_ALUSrc   <= 1'b0;
        bus.ID_EX_RegDst   <= 1'b0;
        bus.ID_EX_ALUOp    <= 2'b00;
      end else begin
        bus.ID_EX_RegWrite <= bus.ID_RegWrite;
        bus.ID_EX_MemToReg <= bus.ID_MemToReg;
        bus.ID_EX_MemRead  <= bus.ID_MemRead;
        bus.ID_EX_MemWrite <= bus.ID_MemWrite;
        bus.ID_EX_ALUSrc   <= bus.ID_ALUSrc;
        bus.ID_EX_RegDst   <= bus.ID_RegDst;
        bus.ID_EX_ALUOp    <= bus.ID_ALUOp;
      end
    end
  end

  // Saturating stall-cycle counter; a flushed stall does not count as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stall_count <= CNT_ZERO;
    end else if (load_use && !bus.flush && (bus.stall_count != CNT_MAX)) begin
      bus.stall_count <= bus.stall_count + CNT_ONE;
    end else begin
      bus.stall_count <= bus.stall_count;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_hazard_stage
// Scoreboard bench: each driven ID instruction pushes the expected ID/EX
// contents (and stall_count) computed from a bench-side pipeline model; after
// the clock edge the entry is popped and compared. A 2-bit counter is used so
// saturation is reachable.
// ---------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic        regwrite, memtoreg, memread, memwrite, alusrc, regdst;
    logic [1:0]  aluop;
  } stage_t;

  typedef struct packed {
    stage_t      st;
    logic [CW-1:0] cnt;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     failures = 0;
  stage_t m;          // model of the ID/EX register contents
  int     m_cnt = 0;  // model of stall_count
  exp_t   q[$];

  id_ex_hazard_if #(.BIT_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(CW)) bus ();

  id_ex_hazard_stage #(.BIT_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input stage_t s, input logic f);
    bus.IF_ID_Rs      = s.rs;
    bus.IF_ID_Rt      = s.rt;
    bus.IF_ID_Rd      = s.rd;
    bus.ID_ReadData1  = s.d1;
    bus.ID_ReadData2  = s.d2;
    bus.ID_SignExtImm = s.imm;
    bus.ID_RegWrite   = s.regwrite;
    bus.ID_MemToReg   = s.memtoreg;
    bus.ID_MemRead    = s.memread;
    bus.ID_MemWrite   = s.memwrite;
    bus.ID_ALUSrc     = s.alusrc;
    bus.ID_RegDst     = s.regdst;
    bus.ID_ALUOp      = s.aluop;
    bus.flush         = f;
  endtask

  task automatic compare_state(input exp_t e);
    chk("id_ex_rs",   bus.ID_EX_Rs, e.st.rs);
    chk("id_ex_rt",   bus.ID_EX_Rt, e.st.rt);
    chk("id_ex_rd",   bus.ID_EX_Rd, e.st.rd);
    chk("id_ex_rd1",  bus.ID_EX_ReadData1, e.st.d1);
    chk("id_ex_rd2",  bus.ID_EX_ReadData2, e.st.d2);
    chk("id_ex_imm",  bus.ID_EX_SignExtImm, e.st.imm);
    chk("id_ex_ctrl", {bus.ID_EX_RegWrite, bus.ID_EX_MemToReg, bus.ID_EX_MemRead,
                       bus.ID_EX_MemWrite, bus.ID_EX_ALUSrc, bus.ID_EX_RegDst, bus.ID_EX_ALUOp},
                      {e.st.regwrite, e.st.memtoreg, e.st.memread, e.st.memwrite,
                       e.st.alusrc, e.st.regdst, e.st.aluop});
    chk("stall_count", bus.stall_count, e.cnt);
  endtask

  // One pipeline cycle: drive at negedge, check hazard outputs, predict, compare after posedge.
  task automatic step(input stage_t s, input logic f);
    logic   hz;
    stage_t nxt;
    exp_t   e;
    @(negedge clk);
    drive(s, f);
    #1;
    hz = m.memread && (m.rt != 5'd0) && ((m.rt == s.rs) || (m.rt == s.rt));
    chk("stall",       bus.stall, hz);
    chk("pcwrite",     bus.PCWrite, !hz || f);
    chk("if_id_write", bus.IF_ID_Write, !hz || f);
    nxt = s;
    if (f) begin
      nxt = '0;
    end else if (hz) begin
      {nxt.regwrite, nxt.memtoreg, nxt.memread, nxt.memwrite, nxt.alusrc, nxt.regdst} = 6'b000000;
      nxt.aluop = 2'b00;
    end
    if (hz && !f && m_cnt < CNT_MAX) m_cnt++;
    e.st  = nxt;
    e.cnt = m_cnt[CW-1:0];
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = q.pop_front();
      compare_state(e);
      m = e.st;
    end
  endtask

  function automatic stage_t lw(input logic [4:0] rt);
    stage_t s = '0;
    s.rs = 5'd1; s.rt = rt; s.d1 = 32'h100; s.imm = 32'h4;
    s.regwrite = 1'b1; s.memtoreg = 1'b1; s.memread = 1'b1; s.alusrc = 1'b1;
    return s;
  endfunction

  function automatic stage_t alu(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] d1);
    stage_t s = '0;
    s.rs = rs; s.rt = rt; s.rd = rd; s.d1 = d1; s.d2 = 32'h22;
    s.regwrite = 1'b1; s.regdst = 1'b1; s.aluop = 2'b10;
    return s;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_spec"}, {bus.ID_EX_Rs, bus.ID_EX_Rt, bus.ID_EX_Rd}, 64'd0);
    chk({tag, "_data"}, bus.ID_EX_ReadData1 | bus.ID_EX_ReadData2 | bus.ID_EX_SignExtImm, 64'd0);
    chk({tag, "_ctrl"}, {bus.ID_EX_RegWrite, bus.ID_EX_MemToReg, bus.ID_EX_MemRead,
                         bus.ID_EX_MemWrite, bus.ID_EX_ALUSrc, bus.ID_EX_RegDst, bus.ID_EX_ALUOp}, 64'd0);
    chk({tag, "_cnt"},   bus.stall_count, 64'd0);
    chk({tag, "_stall"}, bus.stall, 64'd0);
    chk({tag, "_pcw"},   {bus.PCWrite, bus.IF_ID_Write}, 64'd3);
  endtask

  initial begin
    stage_t s;
    int     sat_seq[5] = '{1, 2, 3, 3, 3};
    m = '0;
    drive('0, 1'b0);

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // Pass-through
    step(alu(5'd1, 5'd2, 5'd3, 32'h11), 1'b0);

    // Load-use: one bubble, then the held dependent instruction advances
    step(lw(5'd5), 1'b0);
    step(alu(5'd5, 5'd6, 5'd7, 32'h33), 1'b0);
    chk("loaduse_cnt", bus.stall_count, 64'd1);
    step(alu(5'd5, 5'd6, 5'd7, 32'h33), 1'b0);

    // $zero destination never stalls
    step(lw(5'd0), 1'b0);
    step(alu(5'd0, 5'd0, 5'd4, 32'h44), 1'b0);

    // Flush coinciding with a load-use hazard
    step(lw(5'd5), 1'b0);
    step(alu(5'd5, 5'd2, 5'd9, 32'h55), 1'b1);
    step(alu(5'd5, 5'd2, 5'd9, 32'h55), 1'b0);

    // Random mix with small register numbers so hazards are frequent
    for (int i = 0; i < 24; i++) begin
      s = '0;
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.rd = 5'($urandom_range(0, 31));
      s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
      {s.regwrite, s.memtoreg, s.memread, s.memwrite, s.alusrc, s.regdst} = 6'($urandom);
      s.aluop = 2'($urandom);
      step(s, ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in the middle of a stall
    step('0, 1'b0);
    step(lw(5'd5), 1'b0);
    @(negedge clk);
    drive(alu(5'd5, 5'd1, 5'd2, 32'h66), 1'b0);
    #1;
    chk("midstall_pre", bus.stall, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("midstall");
    m = '0;
    m_cnt = 0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Saturation of the 2-bit counter over five separate load-use events
    for (int i = 0; i < 5; i++) begin
      step(lw(5'd5), 1'b0);
      step(alu(5'd5, 5'd1, 5'd2, 32'h77), 1'b0);
      chk("sat_seq", bus.stall_count, 64'(sat_seq[i]));
      step(alu(5'd5, 5'd1, 5'd2, 32'h77), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
